uart_rx_mmio: RTL
=================

// Module: uart_rx_mmio
// PURPOSE
//  Console input path: host-to-core counterpart of the putchar sink at 0x10000000. Deserialises 8N1 UART on `rx`,
//  buffers bytes in a FIFO, presents them as a memory-mapped responder on the Pipeline data bus (same
//  valid/write/wmask/wdata/addr/rdata protocol and 1-cycle read latency as Memory32). Top level muxes rdata on rd_hit.
// PARAMETERS
//  BASE_ADDR  32'h10000100  8-byte-aligned register window base
//  CLK_DIV    868           clk cycles per bit (>=4); 100 MHz / 115200 baud
//  FIFO_AW    3             FIFO depth = 2**FIFO_AW entries
// PORTS
//  clk      in   1   clock, rising edge
//  rstn     in   1   asynchronous active-low reset
//  rx       in   1   serial input, async, idle high
//  valid    in   1   bus request
//  write    in   1   1=write, 0=read
//  wmask    in   4   byte write enables
//  wdata    in   32  write data
//  addr     in   32  byte address
//  rdata    out  32  read data, registered, valid the cycle after the request
//  rd_hit   out  1   registered: rdata belongs to this block this cycle
//  irq      out  1   only with UART_RX_IRQ_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rstn=0): FSM IDLE, FIFO empty, ovr=frm=0, rdata=0, rd_hit=0, irq=0, rx synchronisers=1.
//  Mid-reset frame is lost; after release a fresh falling edge is required.
//  rx: 2-FF synchroniser, plus prev-sample reg for falling-edge detect.
//  Select: sel = valid & (addr[31:3]==BASE_ADDR[31:3]); offset = addr[2].
//  FSM (bit counter 0..CLK_DIV-1, bit index 0..7):
//   IDLE  -> START on synced falling edge; counter loaded with CLK_DIV/2.
//   START -> at counter expiry: rx=0 -> DATA (counter=CLK_DIV); rx=1 -> IDLE (glitch, nothing recorded).
//   DATA  -> sample every CLK_DIV cycles, LSB first, into shift reg; after bit 7 -> STOP.
//   STOP  -> sample after CLK_DIV: rx=1 -> push byte; rx=0 -> frm=1, byte discarded. Both -> IDLE.
//  Break (line held low): one frame error, then IDLE waits for a new high->low edge.
//  Registers:
//   +0 RXDATA  read: {empty,23'b0,byte}. Non-empty: byte=head, pop. Empty: 32'h8000_0000, no pop.
//              Writes ignored.
//   +4 STATUS  read: {29'b0,frm,ovr,nonempty}, no side effect. Write with wmask[0]: wdata[1]=1 clears ovr,
//              wdata[2]=1 clears frm (W1C).
//  Read timing: rdata/rd_hit update on the edge that sees sel&!write; rd_hit=1 exactly one cycle per read.
//  Writes: no response cycle; rd_hit=0.
//  FIFO full on push: byte dropped, ovr=1 (sticky).
//  Push+pop same cycle: pop returns old head, push accepted even when full, no overrun.
//   Push into empty FIFO with simultaneous RXDATA read returns empty (push not bypassed).
//  Clear of a flag in the same cycle as a new set: set wins.
//  FIFO pointers FIFO_AW+1 bits with wrap bit; full = MSBs differ, low bits equal.
// CONFIGURATION
//  UART_RX_IRQ_EN defined:
//   - irq port and +4 bit 3 "irqen" (R/W via wmask[0], reset 0).
//   - irq = registered (irqen & (nonempty | ovr | frm)); 1-cycle lag.
//  Undefined: no irq port; bit 3 reads 0; writes to it ignored.
// STRUCTURE
//  Shared include uart_defs.vh:
//   - register offsets: RXDATA_OFS=0, STATUS_OFS=4.
//   - STATUS bit positions.
//   - RXDATA empty-flag bit (31).
//   - FSM state encodings IDLE/START/DATA/STOP.
//  Sub-module rx_fifo (params DW=8, AW=FIFO_AW): clk, rstn, push, din, pop, dout, empty, full.
//   Registered storage; dout = head, combinational.
//  Top holds synchroniser, FSM, bus decode, status flags.
// TESTING (CLK_DIV=8, FIFO_AW=2, BASE_ADDR=32'h10000100)
//  1 Serialise 8'h41 on rx, read 0x10000100 -> next-cycle rdata=32'h00000041, rd_hit=1;
//    re-read -> 32'h80000000.
//  2 Send 0x55,0xAA,0x0F,0xF0,0x33 without reads -> four reads return 55,AA,0F,F0;
//    STATUS=32'h2 (ovr); write 32'h2 to +4 -> STATUS=0.
//  3 Stop bit driven 0 on byte 0x7E -> FIFO stays empty, STATUS=32'h4;
//    3-cycle rx low pulse -> no frame, STATUS unchanged.
//  4 Assert rstn=0 in DATA bit 4 -> rdata=0, FIFO empty, flags 0;
//    next full frame 0xC3 received correctly.
//  5 FIFO full; RXDATA read coincides with 5th byte's push cycle -> returns byte 1, ovr stays 0,
//    then 4 further reads drain bytes 2..5.
//  6 UART_RX_IRQ_EN: write 32'h8 to +4, send 0x01 -> irq=1 within 1 cycle of push;
//    read RXDATA -> irq=0 one cycle after pop.

Source files
------------

// File: rtl/uart_rx_mmio_pkg.sv
// uart_rx_mmio_pkg
//   Shared definitions for the memory-mapped UART receiver: register
//   offsets, STATUS bit positions, the RXDATA empty flag and the receive
//   FSM state encoding.
//   No ports (package).
package uart_rx_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam logic [2:0] RXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam int ST_NONEMPTY_BIT = 0;
  localparam int ST_OVR_BIT      = 1;
  localparam int ST_FRM_BIT      = 2;
  localparam int ST_IRQEN_BIT    = 3;

  localparam int          RXDATA_EMPTY_BIT  = 31;
  localparam logic [31:0] RXDATA_EMPTY_WORD = 32'h8000_0000;

endpackage

// File: rtl/uart_rx_mmio_rx_fifo.sv
// rx_fifo
//   Small synchronous FIFO for received bytes. Head is presented
//   combinationally on dout. A push while full is only accepted when a pop
//   happens in the same cycle (the popped slot is reused).
// Ports:
//   clk, rstn      clock, async active-low reset
//   push, din      write request and data
//   pop            read request (ignored when empty)
//   dout           current head entry
//   empty, full    occupancy flags
module rx_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Wrap bit distinguishes full from empty when the low bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio
//   8N1 UART receiver with a byte FIFO, exposed as a memory-mapped bus
//   responder with 1-cycle registered read latency.
//   Optional feature macro: UART_RX_IRQ_EN adds the irq port and the irqen
//   bit (STATUS bit 3).
// Registers (window at BASE_ADDR, 8 bytes):
//   +0 RXDATA  read pops head: {empty,23'b0,byte}; writes ignored
//   +4 STATUS  {frm,ovr,nonempty}; wmask[0] write: W1C ovr/frm, irqen R/W
// Ports:
//   clk, rstn              clock, async active-low reset
//   rx                     async serial input, idle high
//   valid, write, wmask,   bus request
//   wdata, addr
//   rdata, rd_hit          registered read response
//   irq                    level interrupt (UART_RX_IRQ_EN only)
//
// state   | meaning
// IDLE    | waiting for a falling edge on synced rx
// START   | half-bit wait, confirm start bit still low
// DATA    | sampling 8 data bits, LSB first, one per CLK_DIV
// STOP    | sampling stop bit; push byte or flag framing error
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h10000100,
  parameter int          CLK_DIV   = 868,
  parameter int          FIFO_AW   = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx,
  input  logic        valid,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic [31:0] addr,
  output logic [31:0] rdata,
  output logic        rd_hit
`ifdef UART_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLK_DIV - 1);

  logic      rx_s1, rx_s2, rx_prev;
  logic      rx_fall;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push_q;
  logic          ferr_q;

  logic       sel, is_status, rd_req, wr_req, stat_wr;
  logic       pop;
  logic [7:0] fifo_dout;
  logic       fifo_empty, fifo_full;
  logic       ovr, frm;
  logic       ovr_set;
  logic [31:0] status_word;

  // Synchroniser reset to idle-high so no spurious edge is seen out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_fall) begin
            state <= ST_START;
            cnt   <= HALF_LD;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            if (!rx_s2) begin
              state   <= ST_DATA;
              cnt     <= FULL_LD;
              bit_idx <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s2, shreg[7:1]};
            cnt   <= FULL_LD;
            if (bit_idx == 3'd7) state <= ST_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            // A held-low line ends here with one framing error; IDLE then
            // needs the line to rise before another start is seen.
            if (rx_s2) push_q <= 1'b1;
            else       ferr_q <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sel       = valid & (addr[31:3] == BASE_ADDR[31:3]);
  assign is_status = (addr[2] == STATUS_OFS[2]);
  assign rd_req    = sel & ~write;
  assign wr_req    = sel & write;
  assign stat_wr   = wr_req & is_status & wmask[0];
  assign pop       = rd_req & ~is_status & ~fifo_empty;

  rx_fifo #(
    .DW(8),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push_q),
    .din  (shreg),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // A simultaneous pop frees the slot, so that push is not an overrun.
  assign ovr_set = push_q & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovr <= 1'b0;
      frm <= 1'b0;
    end else begin
      if (ovr_set)                          ovr <= 1'b1;
      else if (stat_wr & wdata[ST_OVR_BIT]) ovr <= 1'b0;
      if (ferr_q)                           frm <= 1'b1;
      else if (stat_wr & wdata[ST_FRM_BIT]) frm <= 1'b0;
    end
  end

`ifdef UART_RX_IRQ_EN
  logic irqen;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irqen <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (stat_wr) irqen <= wdata[ST_IRQEN_BIT];
      irq <= irqen & (~fifo_empty | ovr | frm);
    end
  end
`endif

  always_comb begin
    status_word                  = '0;
    status_word[ST_NONEMPTY_BIT] = ~fifo_empty;
    status_word[ST_OVR_BIT]      = ovr;
    status_word[ST_FRM_BIT]      = frm;
`ifdef UART_RX_IRQ_EN
    status_word[ST_IRQEN_BIT]    = irqen;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata  <= '0;
      rd_hit <= 1'b0;
    end else begin
      rd_hit <= rd_req;
      if (rd_req) begin
        if (is_status)       rdata <= status_word;
        else if (fifo_empty) rdata <= RXDATA_EMPTY_WORD;
        else                 rdata <= {24'b0, fifo_dout};
      end
    end
  end

  logic unused_bits;
`ifdef UART_RX_IRQ_EN
  assign unused_bits = ^{wmask[3:1], wdata[31:4], wdata[0], addr[1:0]};
`else
  assign unused_bits = ^{wmask[3:1], wdata[31:3], wdata[0], addr[1:0]};
`endif

endmodule
